// File: rtl/carry_skip_seq_adder_ctrl.sv
// Sequential WIDTH-bit adder: one 4-bit carry-skip slice is reused once per
// nibble, LSB first, with the inter-slice carry held in a register.
// Operands arrive on a valid/ready request port; the result leaves on a
// valid/ready response port and is held stable until it is taken.
module carry_skip_seq_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             busy
);

  localparam int NSLICE = WIDTH / 4;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            carry;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [3:0]      slice_a, slice_b, slice_sum;
  logic            slice_cout;

  // 4-bit carry-skip slice: rippled generate/propagate chain, with the
  // carry-in bypassing the chain when every bit propagates.
  function automatic logic [4:0] carry_skip4(input logic [3:0] a,
                                             input logic [3:0] b,
                                             input logic       cin);
    logic [3:0] p, g, s;
    logic [4:0] c;
    p    = a ^ b;
    g    = a & b;
    c[0] = cin;
    for (int i = 0; i < 4; i++) c[i+1] = g[i] | (p[i] & c[i]);
    s = p ^ c[3:0];
    return {((&p) ? cin : c[4]), s};
  endfunction

  // Signed overflow: operands agree in sign but the result does not.
  function automatic logic ovf_calc(input logic a_msb,
                                    input logic b_msb,
                                    input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and handshake outputs, all decoded from state.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Select the current nibble of each operand and run it through the slice.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (cnt == CW'(i)) begin
        slice_a = a_reg[4*i +: 4];
        slice_b = b_reg[4*i +: 4];
      end
    end
    {slice_cout, slice_sum} = carry_skip4(slice_a, slice_b, carry);
  end

  // Datapath: capture operands on accept, then write one sum nibble per
  // RUN cycle; the result registers are untouched in DONE so they stay stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      carry     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      out_sum   <= '0;
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= in_a;
            b_reg     <= in_b;
            carry     <= in_cin;
            cnt       <= '0;
            out_sum   <= '0;
            out_carry <= 1'b0;
            out_ovf   <= 1'b0;
          end
        end
        RUN: begin
          for (int i = 0; i < NSLICE; i++) begin
            if (cnt == CW'(i)) out_sum[4*i +: 4] <= slice_sum;
          end
          carry <= slice_cout;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            out_carry <= slice_cout;
            out_ovf   <= ovf_calc(a_reg[WIDTH-1], b_reg[WIDTH-1], slice_sum[3]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_carry_skip_seq_adder_ctrl.sv
// Scoreboard bench for carry_skip_seq_adder_ctrl (WIDTH=16): accepted
// requests push a reference a+b+cin result; a monitor compares every
// presented result against the queue head.
module tb_carry_skip_seq_adder_ctrl;

  localparam int W  = 16;
  localparam int NS = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_carry;
  logic         out_ovf;
  logic         busy;

  carry_skip_seq_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
    int           acc_cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   ready_mode = 0;   // 0: always ready, 1: random, 2: held low
  logic prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference model: plain wide addition plus sign rule for overflow.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input int at);
    exp_t e;
    logic [W:0] full;
    full      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    e.sum     = full[W-1:0];
    e.carry   = full[W];
    e.ovf     = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
    e.acc_cyc = at;
    return e;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Consumer ready generator.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: records accepts and checks every presented result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (in_valid && in_ready) q.push_back(model(in_a, in_b, in_cin, cyc));
        if (out_valid) begin
          if (q.size() == 0) begin
            fail_now("unexpected_result");
          end else begin
            e = q[0];
            if (!prev_valid) chk("latency", 32'(cyc - e.acc_cyc), 32'(NS + 1));
            chk("sum", 32'(out_sum), 32'(e.sum));
            chk("carry", 32'(out_carry), 32'(e.carry));
            chk("ovf", 32'(out_ovf), 32'(e.ovf));
            chk("in_ready_in_done", 32'(in_ready), 32'd0);
            chk("busy_in_done", 32'(busy), 32'd1);
            if (out_ready) void'(q.pop_front());
          end
        end
        prev_valid = out_valid;
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_sum"},       32'(out_sum),   32'd0);
    chk({tag, "_carry"},     32'(out_carry), 32'd0);
    chk({tag, "_ovf"},       32'(out_ovf),   32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
  endtask

  // Issue one request after gap idle cycles; returns at the negedge after accept.
  task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input int gap);
    int n;
    repeat (gap + 1) @(posedge clk);
    #1;
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        fail_now("accept_timeout");
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);
    @(negedge clk);
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("in_ready_after_accept", 32'(in_ready), 32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 || busy) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        fail_now("drain_timeout");
        q.delete();
        return;
      end
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed arithmetic cases.
    do_add(16'h00FF, 16'h0001, 1'b0, 1); drain();
    do_add(16'hFFFF, 16'h0000, 1'b1, 0); drain();
    do_add(16'h7FFF, 16'h0001, 1'b0, 0); drain();
    do_add(16'h8000, 16'h8000, 1'b0, 0); drain();

    // Consumer stall with a pending request.
    ready_mode = 2;
    do_add(16'h0F0F, 16'h00F1, 1'b1, 0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) fail_now("done_timeout");
    in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b1; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
    end
    ready_mode = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("idle_after_handover", 32'(in_ready), 32'd1);
    chk("valid_after_handover", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    // Reset in the middle of RUN.
    do_add(16'hAAAA, 16'h5555, 1'b1, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_release_in_ready", 32'(in_ready), 32'd1);
    do_add(16'h1234, 16'h4321, 1'b0, 0); drain();

    // Randomised traffic with producer gaps and consumer stalls.
    ready_mode = 1;
    for (int i = 0; i < 500; i++) begin
      do_add(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 3));
    end
    drain();
    ready_mode = 0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
